apb4_master: RTL and testbench
==============================

Name: apb4_master

Overview:
APB4 initiator (requester side) that turns single-word commands from an internal valid/ready command port into compliant APB4 SETUP/ACCESS transfers. It returns read data and error status on a valid/ready response port. It is the counterpart of the CSR APB4 slave bridge and drives register blocks from test harnesses, debug/JTAG bridges or an on-chip sequencer. One outstanding transfer at a time, with a bounded ACCESS phase via a timeout.

Parameters:
ADDR_WIDTH, 32, APB address width (paddr, cmd_addr).
DATA_WIDTH, 32, APB data width; must be 8, 16 or 32; strobe width is DATA_WIDTH/8.
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte enables
cmd_prot  in  3  protection attributes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  1  pslverr or timeout
rsp_timeout  out  1  transfer aborted by timeout
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pprot  out  3  APB protection
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error, sampled only with pready in ACCESS

Behaviour:
- Reset: state=IDLE. psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the timeout counter are all 0. Reset asserted mid-transfer drops psel/penable immediately and discards the transfer; no response is produced.
- All APB and rsp_* outputs are registered. cmd_ready = (state==IDLE) combinationally, so it is 1 from the first cycle after reset.
- IDLE: on cmd_valid & cmd_ready, latch the command into the APB registers and go to SETUP.
  - Write: pwdata=cmd_wdata, pstrb=cmd_strb.
  - Read: pwdata=0, pstrb=0. APB4 requires zero strobes on reads.
- SETUP: psel=1, penable=0, for exactly one cycle, then go to ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite, pwdata, pstrb and pprot stay stable for the whole transfer.
  - pready=1: capture rsp_rdata (prdata if read, else 0), rsp_err=pslverr, rsp_timeout=0. Clear psel/penable, go to RESP.
  - pready=0: increment the counter. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1, abort: clear psel/penable, rsp_rdata=0, rsp_err=1, rsp_timeout=1, go to RESP.
  - If pready rises in the same cycle the timeout would fire, pready wins.
  - Counter clears on entry to SETUP. Its width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- RESP: rsp_valid=1, and rsp_* stay held until rsp_ready. On handshake: rsp_valid=0, go to IDLE.
- paddr, pwrite and pprot keep their last values after a transfer; pwdata and pstrb also keep their last values.
- Latency (pready already high): command accepted at edge N, psel at N+1, penable at N+2, rsp_valid at N+3. Each pready wait state adds one cycle.
- Minimum issue interval: 4 cycles per transfer (IDLE→SETUP→ACCESS→RESP).
- At most one transfer is in flight; a new command is never accepted while rsp_valid=1.

Test Plan:
- Write 0xDEADBEEF to 0x10 with strb=0xF, pready tied 1 → one SETUP cycle then one ACCESS cycle with paddr=0x10, pwrite=1, pstrb=0xF; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x04 with 3 pready-low wait states and prdata=0x12345678 → penable high for 4 cycles, pstrb=0, rsp_rdata=0x12345678, rsp_err=0.
- Write with pslverr=1 on the pready cycle → rsp_err=1, rsp_timeout=0; the next command is accepted only after the rsp handshake.
- TIMEOUT_CYCLES=16, pready held 0 → psel/penable drop after exactly 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- rsp_ready held 0 for 5 cycles with cmd_valid held 1 → rsp_* stable, cmd_ready=0 throughout; after the handshake cmd_ready=1 and the second transfer starts in SETUP next cycle.
- rst pulsed during ACCESS → psel=penable=0 immediately, rsp_valid=0, cmd_ready=1 after release, and the next read completes normally.

Source files
------------

// File: rtl/apb4_master.sv
// APB4 requester: turns single-word valid/ready commands into SETUP/ACCESS transfers
// and returns read data plus error/timeout status on a valid/ready response port.
module apb4_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state_q,       state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,         cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  pwrite_q,      pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,       pstrb_d;
  logic [2:0]            pprot_q,       pprot_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  timeout_hit;

  // A zero TIMEOUT_CYCLES leaves the ACCESS phase unbounded.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pprot_d   = cmd_prot;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb  : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A completing pready takes priority over a timeout in the same cycle.
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (timeout_hit) begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
// Self-checking bench for apb4_master: directed corner cases plus randomized transfers
// checked cycle by cycle against a transaction-level model of the APB4 requester.
module tb_apb4_master;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int numChecks = 0;
  int numPassed = 0;

  apb4_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual === expected) numPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scrambleCmd();
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = SW'($urandom);
    cmd_prot  = 3'($urandom);
  endtask

  // One complete transfer; expectations come from transaction-level rules only.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [SW-1:0] strb, input logic [2:0] prot, input int waitStates,
                               input logic slvErr, input logic [DW-1:0] rdata, input int rspDelay,
                               input bit holdCmd);
    logic [DW-1:0] expWdata;
    logic [SW-1:0] expStrb;
    logic [DW-1:0] expRdata;
    logic          expErr;
    bit            expTimeout;
    int            accessCycles;

    expWdata     = wr ? wdata : '0;
    expStrb      = wr ? strb : '0;
    expTimeout   = (TIMEOUT != 0) && (waitStates >= TIMEOUT);
    accessCycles = expTimeout ? TIMEOUT : waitStates + 1;
    expRdata     = (wr || expTimeout) ? '0 : rdata;
    expErr       = expTimeout ? 1'b1 : slvErr;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    pready = 1'b0;
    checkOutput("accept_cmd_ready", cmd_ready, 1);
    checkOutput("accept_psel", psel, 0);
    step();

    cmd_valid = 1'b0;
    scrambleCmd();
    checkOutput("setup_psel", psel, 1);
    checkOutput("setup_penable", penable, 0);
    checkOutput("setup_paddr", paddr, addr);
    checkOutput("setup_pwrite", pwrite, wr);
    checkOutput("setup_pwdata", pwdata, expWdata);
    checkOutput("setup_pstrb", pstrb, expStrb);
    checkOutput("setup_pprot", pprot, prot);
    checkOutput("setup_cmd_ready", cmd_ready, 0);
    step();

    for (int k = 0; k < accessCycles; k++) begin
      checkOutput("access_psel", psel, 1);
      checkOutput("access_penable", penable, 1);
      checkOutput("access_paddr", paddr, addr);
      checkOutput("access_pwdata", pwdata, expWdata);
      checkOutput("access_pstrb", pstrb, expStrb);
      checkOutput("access_rsp_valid", rsp_valid, 0);
      pready  = (k == waitStates);
      prdata  = pready ? rdata : $urandom;
      pslverr = pready ? slvErr : 1'($urandom);
      step();
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;

    if (holdCmd) begin
      cmd_valid = 1'b1;
      scrambleCmd();
    end
    for (int d = 0; d <= rspDelay; d++) begin
      checkOutput("resp_valid", rsp_valid, 1);
      checkOutput("resp_rdata", rsp_rdata, expRdata);
      checkOutput("resp_err", rsp_err, expErr);
      checkOutput("resp_timeout", rsp_timeout, expTimeout);
      checkOutput("resp_psel", psel, 0);
      checkOutput("resp_penable", penable, 0);
      checkOutput("resp_cmd_ready", cmd_ready, 0);
      checkOutput("resp_paddr_held", paddr, addr);
      checkOutput("resp_pwdata_held", pwdata, expWdata);
      rsp_ready = (d == rspDelay);
      step();
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("done_rsp_valid", rsp_valid, 0);
    checkOutput("done_cmd_ready", cmd_ready, 1);
    checkOutput("done_psel", psel, 0);
  endtask

  initial begin
    int ws;
    int dly;
    logic wr;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    step();
    step();
    checkOutput("reset_psel", psel, 0);
    checkOutput("reset_penable", penable, 0);
    checkOutput("reset_paddr", paddr, 0);
    checkOutput("reset_pwdata", pwdata, 0);
    checkOutput("reset_pstrb", pstrb, 0);
    checkOutput("reset_pwrite", pwrite, 0);
    checkOutput("reset_pprot", pprot, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_rsp_timeout", rsp_timeout, 0);
    rst = 1'b0;
    step();
    checkOutput("post_reset_cmd_ready", cmd_ready, 1);

    // Directed corner cases first.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0, 1'b0);
    applyStimulus(1'b0, 32'h04, 32'hFFFFFFFF, 4'hF, 3'd2, 3, 1'b0, 32'h12345678, 0, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 4'h5, 3'd1, 1, 1'b1, 32'h0, 2, 1'b1);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 3'd7, TIMEOUT, 1'b0, 32'hAAAA5555, 0, 1'b0);
    applyStimulus(1'b0, 32'h34, 32'h0, 4'h0, 3'd3, TIMEOUT - 1, 1'b0, 32'h0BADC0DE, 0, 1'b0);
    applyStimulus(1'b1, 32'h38, 32'h11223344, 4'h3, 3'd4, 0, 1'b0, 32'h0, 5, 1'b1);
    applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0, 3'd5, 0, 1'b0, 32'h55667788, 0, 1'b0);

    // Reset pulsed while the slave is stalling in ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_prot = 3'd6;
    step();
    cmd_valid = 1'b0;
    step();
    pready = 1'b0;
    step();
    checkOutput("prereset_penable", penable, 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_psel", psel, 0);
    checkOutput("midreset_penable", penable, 0);
    checkOutput("midreset_rsp_valid", rsp_valid, 0);
    checkOutput("midreset_paddr", paddr, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    checkOutput("postreset_cmd_ready", cmd_ready, 1);
    checkOutput("postreset_rsp_valid", rsp_valid, 0);
    applyStimulus(1'b0, 32'h44, 32'h0, 4'h0, 3'd0, 2, 1'b0, 32'h87654321, 1, 1'b0);

    // Randomized traffic, occasionally straddling the timeout boundary.
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom);
      ws  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(TIMEOUT + 2, TIMEOUT - 2))
                                        : int'($urandom_range(3, 0));
      dly = int'($urandom_range(3, 0));
      applyStimulus(wr, {$urandom} & 32'hFFFF_FFFC, $urandom, SW'($urandom), 3'($urandom), ws,
                    ($urandom_range(3, 0) == 0), $urandom, dly, 1'($urandom));
    end

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
